// File: rtl/cdm_pipe_mult.sv
// cdm_pipe_mult: parametrised 3-stage carry-disregard approximate multiplier.
// The low L product columns are formed as the OR of their partial-product bits, so no
// carry is generated into or out of them; the upper columns are summed exactly.
// A per-beat mode selects the exact or approximate product. Flow control is a
// stall-all valid/ready pipeline. Two saturating counters track delivered results
// and the accumulated approximation error.
module cdm_pipe_mult #(
  parameter int unsigned W     = 8,
  parameter int unsigned L     = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_r,
  output logic             out_mode,
  input  logic             err_clr,
  output logic [ACC_W-1:0] err_acc,
  output logic [ACC_W-1:0] txn_cnt
);

  localparam int unsigned ProdW = 2 * W;
  // Wide enough that err_acc + e cannot wrap before the saturation compare.
  localparam int unsigned SumW  = ((ACC_W > ProdW) ? ACC_W : ProdW) + 1;
  localparam logic [ProdW-1:0] LowMask = {ProdW{1'b1}} >> (ProdW - L);
  localparam logic [ACC_W-1:0] AccMax  = '1;

  logic             en;
  logic             deliver;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic             s1_mode_q;

  logic             s2_valid_q;
  logic             s2_mode_q;
  logic [ProdW-1:0] s2_hi_q;
  logic [ProdW-1:0] s2_lo_sum_q;
  logic [ProdW-1:0] s2_lo_or_q;

  logic [ProdW-1:0] s3_err_q;

  logic [ProdW-1:0] pp;
  logic [ProdW-1:0] hi_d;
  logic [ProdW-1:0] lo_sum_d;
  logic [ProdW-1:0] lo_or_d;
  logic [ProdW-1:0] r_d;
  logic [ProdW-1:0] err_d;
  logic [SumW-1:0]  err_sum;

  // Whole pipeline freezes only while a result waits on the consumer.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign deliver  = out_valid && out_ready;

  // Stage 1: capture operands on accept; a bubble is recorded when nothing is offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= in_a;
        s1_b_q    <= in_b;
        s1_mode_q <= in_mode;
      end
    end
  end

  // Partial products split into exact upper sum, low-column sum and low-column OR.
  always_comb begin
    pp       = '0;
    hi_d     = '0;
    lo_sum_d = '0;
    lo_or_d  = '0;
    for (int i = 0; i < W; i++) begin
      pp       = s1_b_q[i] ? ({{W{1'b0}}, s1_a_q} << i) : '0;
      hi_d     = hi_d + (pp & ~LowMask);
      lo_sum_d = lo_sum_d + (pp & LowMask);
      lo_or_d  = lo_or_d | (pp & LowMask);
    end
  end

  // Stage 2: register the masked partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_hi_q     <= '0;
      s2_lo_sum_q <= '0;
      s2_lo_or_q  <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_q   <= s1_mode_q;
        s2_hi_q     <= hi_d;
        s2_lo_sum_q <= lo_sum_d;
        s2_lo_or_q  <= lo_or_d;
      end
    end
  end

  // Select exact or approximate product and the error it carries.
  always_comb begin
    r_d   = '0;
    err_d = '0;
    if (s2_mode_q) begin
      r_d = s2_hi_q + s2_lo_sum_q;
    end else begin
      // Upper sum has zeros in the low L columns, so OR merges without carries.
      r_d   = s2_hi_q | s2_lo_or_q;
      err_d = s2_lo_sum_q - s2_lo_or_q;
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_mode  <= 1'b0;
      s3_err_q  <= '0;
    end else if (en) begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        out_r    <= r_d;
        out_mode <= s2_mode_q;
        s3_err_q <= err_d;
      end
    end
  end

  assign err_sum = SumW'(err_acc) + SumW'(s3_err_q);

  // Saturating statistics over delivered results; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_acc <= '0;
      txn_cnt <= '0;
    end else if (err_clr) begin
      err_acc <= '0;
      txn_cnt <= '0;
    end else if (deliver) begin
      err_acc <= (err_sum > SumW'(AccMax)) ? AccMax : err_sum[ACC_W-1:0];
      if (txn_cnt != AccMax) begin
        txn_cnt <= txn_cnt + ACC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdm_pipe_mult.sv
// Self-checking bench for cdm_pipe_mult: latency, streaming, backpressure,
// counter saturation and clear, mid-stream reset and a W=4 exhaustive sweep.
module tb_cdm_pipe_mult;

  typedef struct {
    logic [15:0] r;
    logic        m;
  } exp_t;

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r8;
  } exp4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main instance: W=8, L=8, ACC_W=32.
  logic        in_valid = 0, in_mode = 0, out_ready = 0, err_clr = 0;
  logic [7:0]  in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_mode;
  logic [15:0] out_r;
  logic [31:0] err_acc, txn_cnt;

  // Saturation instance: W=8, L=8, ACC_W=12.
  logic        s_valid = 0, s_mode = 0, s_ordy = 1, s_clr = 0;
  logic [7:0]  s_a = 0, s_b = 0;
  logic        s_ready, s_out_valid, s_out_mode;
  logic [15:0] s_r;
  logic [11:0] s_acc, s_txn;

  // Sweep instances: W=4 with L=0 and L=8, sharing stimulus.
  logic        w_valid = 0;
  logic [3:0]  w_a = 0, w_b = 0;
  logic        w0_ready, w0_valid, w0_mode, w8_ready, w8_valid, w8_mode;
  logic [7:0]  w0_r, w8_r;
  logic [31:0] w0_acc, w0_txn, w8_acc, w8_txn;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cdm_pipe_mult #(.W(8), .L(8), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_mode(out_mode), .err_clr(err_clr), .err_acc(err_acc),
    .txn_cnt(txn_cnt)
  );

  cdm_pipe_mult #(.W(8), .L(8), .ACC_W(12)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_a(s_a),
    .in_b(s_b), .in_mode(s_mode), .out_valid(s_out_valid), .out_ready(s_ordy),
    .out_r(s_r), .out_mode(s_out_mode), .err_clr(s_clr), .err_acc(s_acc),
    .txn_cnt(s_txn)
  );

  cdm_pipe_mult #(.W(4), .L(0), .ACC_W(32)) dut_w4l0 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w0_ready), .in_a(w_a),
    .in_b(w_b), .in_mode(1'b0), .out_valid(w0_valid), .out_ready(1'b1),
    .out_r(w0_r), .out_mode(w0_mode), .err_clr(1'b0), .err_acc(w0_acc),
    .txn_cnt(w0_txn)
  );

  cdm_pipe_mult #(.W(4), .L(8), .ACC_W(32)) dut_w4l8 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w8_ready), .in_a(w_a),
    .in_b(w_b), .in_mode(1'b0), .out_valid(w8_valid), .out_ready(1'b1),
    .out_r(w8_r), .out_mode(w8_mode), .err_clr(1'b0), .err_acc(w8_acc),
    .txn_cnt(w8_txn)
  );

  // Reference carry-disregard product straight from the column definition.
  function automatic void ref_mul(input longint unsigned a, input longint unsigned b,
                                  input int w, input int l,
                                  output longint unsigned approx,
                                  output longint unsigned err);
    longint unsigned mask, pp, hi, lo_sum, lo_or;
    mask   = (l == 0) ? 64'd0 : ((64'd1 << l) - 64'd1);
    hi     = 0;
    lo_sum = 0;
    lo_or  = 0;
    for (int i = 0; i < w; i++) begin
      pp     = ((b >> i) & 64'd1) != 0 ? (a << i) : 64'd0;
      hi     = hi + (pp & ~mask);
      lo_sum = lo_sum + (pp & mask);
      lo_or  = lo_or | (pp & mask);
    end
    approx = hi | lo_or;
    err    = lo_sum - lo_or;
  endfunction

  // One cycle on the main instance: drive at negedge, observe just after.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic m, input logic ordy, output logic acc,
                       output logic dlv, output logic [15:0] r, output logic rm);
    longint unsigned ap, er;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      ref_mul(a, b, 8, 8, ap, er);
      e.r = m ? 16'(a * b) : ap[15:0];
      e.m = m;
      sb.push_back(e);
    end
    dlv = out_valid && out_ready;
    r   = out_r;
    rm  = out_mode;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_r !== 16'd0) $display("FAIL reset_out_r: got %0d want 0", out_r); else n_pass++;
    n_total++; if (out_mode !== 1'b0) $display("FAIL reset_out_mode: got %b want 0", out_mode); else n_pass++;
    n_total++; if (err_acc !== 32'd0) $display("FAIL reset_err_acc: got %0d want 0", err_acc); else n_pass++;
    n_total++; if (txn_cnt !== 32'd0) $display("FAIL reset_txn_cnt: got %0d want 0", txn_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0]  av[3], bv[3];
    logic [15:0] cv[3];
    logic        acc, dlv, rm, got;
    logic [15:0] r;
    int          lat;
    exp_t        e;
    av[0] = 255; bv[0] = 255; cv[0] = 16'd63487;
    av[1] = 3;   bv[1] = 3;   cv[1] = 16'd7;
    av[2] = 1;   bv[2] = 200; cv[2] = 16'd200;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, av[k], bv[k], 1'b0, 1'b1, acc, dlv, r, rm);
      n_total++; if (acc !== 1'b1) $display("FAIL single_accept%0d: got %b want 1", k, acc); else n_pass++;
      got = 0;
      lat = 0;
      for (int n = 1; n <= 8 && !got; n++) begin
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, dlv, r, rm);
        if (dlv) begin
          got = 1;
          lat = n;
          e   = sb.pop_front();
          n_total++; if (r !== cv[k]) $display("FAIL single_const%0d: got %0d want %0d", k, r, cv[k]); else n_pass++;
          n_total++; if (r !== e.r || rm !== e.m) $display("FAIL single_model%0d: got %0d/%b want %0d/%b", k, r, rm, e.r, e.m); else n_pass++;
        end
      end
      n_total++; if (lat != 3) $display("FAIL single_latency%0d: got %0d want 3", k, lat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av[4], bv[4];
    logic        mv[4];
    logic [15:0] cv[4];
    logic        acc, dlv, rm;
    logic [15:0] r;
    int          nd;
    exp_t        e;
    av[0] = 255; bv[0] = 255; mv[0] = 0; cv[0] = 16'd63487;
    av[1] = 3;   bv[1] = 3;   mv[1] = 0; cv[1] = 16'd7;
    av[2] = 1;   bv[2] = 200; mv[2] = 0; cv[2] = 16'd200;
    av[3] = 255; bv[3] = 255; mv[3] = 1; cv[3] = 16'd65025;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    n_total++; if (err_acc !== 32'd0 || txn_cnt !== 32'd0) $display("FAIL clr_counters: got %0d/%0d want 0/0", err_acc, txn_cnt); else n_pass++;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive(1'b1, av[c], bv[c], mv[c], 1'b1, acc, dlv, r, rm);
      else       drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, dlv, r, rm);
      if (dlv) begin
        n_total++; if (c != nd + 3) $display("FAIL b2b_cycle%0d: got %0d want %0d", nd, c, nd + 3); else n_pass++;
        if (sb.size() == 0) begin
          n_total++; $display("FAIL b2b_extra: got output %0d want none", r);
        end else begin
          e = sb.pop_front();
          n_total++; if (r !== e.r || rm !== e.m) $display("FAIL b2b_model%0d: got %0d/%b want %0d/%b", nd, r, rm, e.r, e.m); else n_pass++;
          if (nd < 4) begin
            n_total++; if (r !== cv[nd]) $display("FAIL b2b_const%0d: got %0d want %0d", nd, r, cv[nd]); else n_pass++;
          end
        end
        nd++;
      end
    end
    n_total++; if (nd != 4) $display("FAIL b2b_count: got %0d want 4", nd); else n_pass++;
    n_total++; if (txn_cnt !== 32'd4) $display("FAIL b2b_txn_cnt: got %0d want 4", txn_cnt); else n_pass++;
    n_total++; if (err_acc !== 32'd1540) $display("FAIL b2b_err_acc: got %0d want 1540", err_acc); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0]  av[5], bv[5];
    logic        mv[5];
    logic        acc, dlv, rm, ordy;
    logic [15:0] r;
    int          idx, nd;
    exp_t        e;
    av[0] = 255; bv[0] = 255; mv[0] = 0;
    av[1] = 3;   bv[1] = 3;   mv[1] = 0;
    av[2] = 1;   bv[2] = 200; mv[2] = 0;
    av[3] = 15;  bv[3] = 15;  mv[3] = 1;
    av[4] = 100; bv[4] = 7;   mv[4] = 0;
    idx = 0;
    nd  = 0;
    for (int c = 0; c < 30; c++) begin
      ordy = (c >= 8);
      if (c == 8) begin
        n_total++; if (idx != 3) $display("FAIL bp_accepted_during_stall: got %0d want 3", idx); else n_pass++;
      end
      if (idx < 5) drive(1'b1, av[idx], bv[idx], mv[idx], ordy, acc, dlv, r, rm);
      else         drive(1'b0, 8'd0, 8'd0, 1'b0, ordy, acc, dlv, r, rm);
      if (acc) idx++;
      if (c >= 3 && c < 8) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || r !== 16'd63487) $display("FAIL bp_hold%0d: got %b/%0d want 1/63487", c, out_valid, r); else n_pass++;
      end
      if (dlv) begin
        if (sb.size() == 0) begin
          n_total++; $display("FAIL bp_extra: got output %0d want none", r);
        end else begin
          e = sb.pop_front();
          n_total++; if (r !== e.r || rm !== e.m) $display("FAIL bp_order%0d: got %0d/%b want %0d/%b", nd, r, rm, e.r, e.m); else n_pass++;
        end
        nd++;
      end
    end
    n_total++; if (nd != 5 || sb.size() != 0) $display("FAIL bp_drain: got %0d delivered, %0d pending want 5, 0", nd, sb.size()); else n_pass++;
  endtask

  task automatic test_saturation();
    logic found;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_valid = (c < 3);
      s_a     = 8'd255;
      s_b     = 8'd255;
      s_mode  = 1'b0;
      #1;
      if (c == 3) begin
        n_total++; if (s_out_valid !== 1'b1 || s_r !== 16'd63487) $display("FAIL sat_out: got %b/%0d want 1/63487", s_out_valid, s_r); else n_pass++;
      end
    end
    n_total++; if (s_acc !== 12'd4095) $display("FAIL sat_err_acc: got %0d want 4095", s_acc); else n_pass++;
    n_total++; if (s_txn !== 12'd3) $display("FAIL sat_txn_cnt: got %0d want 3", s_txn); else n_pass++;
    @(negedge clk);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 8 && !found; n++) begin
      #1;
      if (s_out_valid) found = 1;
      else @(negedge clk);
    end
    n_total++; if (!found) $display("FAIL sat_wait_result: got timeout want result"); else n_pass++;
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    #1;
    n_total++; if (s_acc !== 12'd0 || s_txn !== 12'd0) $display("FAIL sat_clr: got %0d/%0d want 0/0", s_acc, s_txn); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (s_acc !== 12'd0 || s_txn !== 12'd0 || s_out_valid !== 1'b0) $display("FAIL sat_clr_after: got %0d/%0d/%b want 0/0/0", s_acc, s_txn, s_out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic        acc, dlv, rm;
    logic [15:0] r;
    int          nd;
    for (int k = 0; k < 3; k++) drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1, acc, dlv, r, rm);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_r !== 16'd0) $display("FAIL rstmid_out: got %b/%0d want 0/0", out_valid, out_r); else n_pass++;
    n_total++; if (err_acc !== 32'd0 || txn_cnt !== 32'd0) $display("FAIL rstmid_counters: got %0d/%0d want 0/0", err_acc, txn_cnt); else n_pass++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, dlv, r, rm);
      if (out_valid) nd++;
    end
    n_total++; if (nd != 0) $display("FAIL rstmid_stale: got %0d outputs want 0", nd); else n_pass++;
  endtask

  task automatic test_sweep();
    exp4_t q4[$];
    exp4_t e;
    longint unsigned ap, er;
    int nd;
    nd = 0;
    for (int i = 0; i < 262; i++) begin
      @(negedge clk);
      w_valid = (i < 256);
      w_a     = i[7:4];
      w_b     = i[3:0];
      #1;
      if (i < 256) begin
        ref_mul(64'(w_a), 64'(w_b), 4, 8, ap, er);
        e.r0 = 8'(w_a * w_b);
        e.r8 = ap[7:0];
        q4.push_back(e);
      end
      if (w0_valid) begin
        if (q4.size() == 0) begin
          n_total++; $display("FAIL sweep_extra: got output %0d want none", w0_r);
        end else begin
          e = q4.pop_front();
          n_total++; if (w0_r !== e.r0) $display("FAIL sweep_l0_%0d: got %0d want %0d", nd, w0_r, e.r0); else n_pass++;
          n_total++; if (w8_r !== e.r8 || w8_valid !== 1'b1) $display("FAIL sweep_l8_%0d: got %0d/%b want %0d/1", nd, w8_r, w8_valid, e.r8); else n_pass++;
        end
        nd++;
      end
    end
    w_valid = 1'b0;
    n_total++; if (nd != 256 || q4.size() != 0) $display("FAIL sweep_count: got %0d want 256", nd); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
